regfile_mp: RTL

//  Multi-port register file for the MIPS datapath: NREAD asynchronous read ports and two synchronous

---
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_mp.sv | 86 ++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read/clear bus of the multi-port register file
interface regfile_mp_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREAD      = 2
);
    logic                        clearReq;
    logic                        busy;
    logic                        weA;
    logic                        weB;
    logic [ADDR_WIDTH-1:0]       waA;
    logic [ADDR_WIDTH-1:0]       waB;
    logic [WIDTH-1:0]            wdA;
    logic [WIDTH-1:0]            wdB;
    logic [WIDTH/8-1:0]          wmA;
    logic [WIDTH/8-1:0]          wmB;
    logic [NREAD*ADDR_WIDTH-1:0] readAddr;
    logic [NREAD*WIDTH-1:0]      readData;

    modport master (
        output clearReq, weA, weB, waA, waB, wdA, wdB, wmA, wmB, readAddr,
        input  busy, readData
    );

    modport slave (
        input  clearReq, weA, weB, waA, waB, wdA, wdB, wmA, wmB, readAddr,
        output busy, readData
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - dual-write, NREAD-read register file with sequential clear engine
// Optional BYPASS_EN: same-cycle write-to-read forwarding, per byte, B priority.
module regfile_mp #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [NREAD*WIDTH-1:0] rdAll;
    logic                  wrOkA;
    logic                  wrOkB;

    // A write to the hardwired-zero entry is simply dropped.
    assign wrOkA = bus.weA && !(ZERO_REG != 0 && bus.waA == '0);
    assign wrOkB = bus.weB && !(ZERO_REG != 0 && bus.waB == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A first, then B, so B's overlapping bytes win on a shared address.
                    for (int k = 0; k < NBYTES; k++) begin
                        if (wrOkA && bus.wmA[k])
                            mem[bus.waA][8*k +: 8] <= bus.wdA[8*k +: 8];
                        if (wrOkB && bus.wmB[k])
                            mem[bus.waB][8*k +: 8] <= bus.wdB[8*k +: 8];
                    end
                    if (bus.clearReq) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + 1'b1;
                    if (ptr == ADDR_WIDTH'(DEPTH - 1))
                        state <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.busy = (state == CLEAR);

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic [WIDTH-1:0]      word;

        assign ra = bus.readAddr[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            word = mem[ra];
`ifdef BYPASS_EN
            for (int k = 0; k < NBYTES; k++) begin
                if (wrOkB && bus.wmB[k] && bus.waB == ra)
                    word[8*k +: 8] = bus.wdB[8*k +: 8];
                else if (wrOkA && bus.wmA[k] && bus.waA == ra)
                    word[8*k +: 8] = bus.wdA[8*k +: 8];
            end
`else
`endif
            if (state == CLEAR || (ZERO_REG != 0 && ra == '0))
                word = '0;
        end

        assign rdAll[p*WIDTH +: WIDTH] = word;
    end

    assign bus.readData = rdAll;
endmodule
